pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register carrying {pc4, ins} with a valid/ready handshake.
// A 2-entry skid buffer keeps in_ready registered; supports flush and a stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INS_W     = 32,
    parameter logic [INS_W-1:0]     NOP_INS   = 32'h0000_0000,
    parameter logic [PC_W-1:0]      RESET_PC4 = 32'h0000_3004,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic [INS_W-1:0]  in_ins,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc4,
    output logic [INS_W-1:0]  out_ins,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } occ_state_e;

    occ_state_e          state_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [PC_W-1:0]     out_pc4_r;
    logic [INS_W-1:0]    out_ins_r;
    logic [PC_W-1:0]     skid_pc4_r;
    logic [INS_W-1:0]    skid_ins_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    logic                accept_s;
    logic                pop_s;
    logic                stall_s;
    logic                cnt_sat_s;

    // Handshake qualifiers derived from the registered ready/valid flags.
    always_comb begin
        accept_s  = in_valid & in_ready_r;
        pop_s     = out_valid_r & out_ready;
        stall_s   = out_valid_r & ~out_ready & ~flush;
        cnt_sat_s = (stall_cnt_r == {CNT_W{1'b1}});
    end

    // Occupancy FSM: main entry, skid entry and the registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_pc4_r   <= RESET_PC4;
            out_ins_r   <= NOP_INS;
            skid_pc4_r  <= {PC_W{1'b0}};
            skid_ins_r  <= {INS_W{1'b0}};
        end else if (flush) begin
            // Held beats and any beat accepted this cycle are dropped; out_pc4 keeps its value.
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_ins_r   <= NOP_INS;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        out_pc4_r   <= in_pc4;
                        out_ins_r   <= in_ins;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (pop_s && accept_s) begin
                        out_pc4_r   <= in_pc4;
                        out_ins_r   <= in_ins;
                        state_r     <= ST_ONE;
                    end else if (pop_s) begin
                        out_valid_r <= 1'b0;
                        out_ins_r   <= NOP_INS;
                        state_r     <= ST_EMPTY;
                    end else if (accept_s) begin
                        skid_pc4_r  <= in_pc4;
                        skid_ins_r  <= in_ins;
                        in_ready_r  <= 1'b0;
                        state_r     <= ST_TWO;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        out_pc4_r   <= skid_pc4_r;
                        out_ins_r   <= skid_ins_r;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_TWO;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_ins_r   <= NOP_INS;
                end
            endcase
        end
    end

    // Saturating count of cycles where a held beat was refused downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !cnt_sat_s) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pc4   = out_pc4_r;
    assign out_ins   = out_ins_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard on delivered beats plus per-scenario checks.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] RPC = 32'h0000_3004;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [31:0] in_pc4, in_ins;
    logic        in_ready, out_valid;
    logic [31:0] out_pc4, out_ins;
    logic [15:0] stall_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc4, s_out_ins;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;
    logic [31:0] pc_tab [3];
    logic [31:0] ins_tab[3];

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc4(in_pc4), .in_ins(in_ins),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc4(out_pc4), .out_ins(out_ins),
        .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc4(in_pc4), .in_ins(in_ins),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_pc4(s_out_pc4), .out_ins(s_out_ins),
        .out_ready(out_ready), .flush(flush), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: transfers are decided by values stable between negedge and the next posedge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            sb_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc4=%h ins=%h, required no beat", out_pc4, out_ins);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({out_pc4, out_ins} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_order: got %h_%h, required %h_%h",
                                 out_pc4, out_ins, exp_v[63:32], exp_v[31:0]);
                    end
                end
            end
            if (out_valid === 1'b0) begin
                checks++;
                if (out_ins !== NOP) begin
                    errors++;
                    $display("FAIL nop_when_idle: got %h, required %h", out_ins, NOP);
                end
            end
            if (flush === 1'b1) sb_q.delete();
            else if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back({in_pc4, in_ins});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc4   = pc;
        in_ins   = ins;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h0000_5000, 32'h2401_00FF);
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || out_ins !== NOP || out_pc4 !== RPC || in_ready !== 1'b1 ||
                stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset: got v=%b ins=%h pc4=%h rdy=%b cnt=%0d/%0d, required 0 %h %h 1 0/0",
                         out_valid, out_ins, out_pc4, in_ready, stall_cnt, s_stall_cnt, NOP, RPC);
            end
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pc_tab[i], ins_tab[i]);
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_pc4 !== pc_tab[i] || out_ins !== ins_tab[i] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b %h/%h rdy=%b, required 1 %h/%h 1",
                         i, out_valid, out_pc4, out_ins, in_ready, pc_tab[i], ins_tab[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_ins !== NOP || out_pc4 !== 32'h0000_300C) begin
            errors++;
            $display("FAIL stream_drain: got v=%b %h/%h, required 0 0000300c/%h", out_valid, out_pc4, out_ins, NOP);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, pc_tab[0], ins_tab[0]);
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_pc4 !== pc_tab[0] || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_first: got rdy=%b pc4=%h cnt=%0d, required 1 %h 0", in_ready, out_pc4, stall_cnt, pc_tab[0]);
        end
        drive(1'b1, pc_tab[1], ins_tab[1]);
        cyc();
        drive(1'b1, pc_tab[2], ins_tab[2]);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) cyc();
            checks++;
            if (in_ready !== 1'b0 || out_pc4 !== pc_tab[0] || out_ins !== ins_tab[0] || stall_cnt !== 16'(k)) begin
                errors++;
                $display("FAIL bp_hold_%0d: got rdy=%b %h/%h cnt=%0d, required 0 %h/%h %0d",
                         k, in_ready, out_pc4, out_ins, stall_cnt, pc_tab[0], ins_tab[0], k);
            end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_pc4 !== pc_tab[i] || out_ins !== ins_tab[i] ||
                in_ready !== 1'b1 || stall_cnt !== 16'd4) begin
                errors++;
                $display("FAIL bp_release_%0d: got v=%b %h/%h rdy=%b cnt=%0d, required 1 %h/%h 1 4",
                         i, out_valid, out_pc4, out_ins, in_ready, stall_cnt, pc_tab[i], ins_tab[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got v=%b, required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, pc_tab[0], ins_tab[0]);
        cyc();
        drive(1'b1, pc_tab[1], ins_tab[1]);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h0000_3010, 32'h2403_0003);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_ins !== NOP || in_ready !== 1'b1 ||
            out_pc4 !== pc_tab[0] || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_two: got v=%b ins=%h rdy=%b pc4=%h cnt=%0d, required 0 %h 1 %h 5",
                     out_valid, out_ins, in_ready, out_pc4, stall_cnt, NOP, pc_tab[0]);
        end
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || out_pc4 === 32'h0000_3010) begin
                errors++;
                $display("FAIL flush_discard_%0d: got v=%b pc4=%h, required 0 and not 00003010", i, out_valid, out_pc4);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, pc_tab[0], ins_tab[0]);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (stall_cnt !== 16'(k) || s_stall_cnt !== ((k > 15) ? 4'd15 : 4'(k))) begin
                errors++;
                $display("FAIL sat_%0d: got cnt16=%0d cnt4=%0d, required %0d %0d",
                         k, stall_cnt, s_stall_cnt, k, (k > 15) ? 15 : k);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got cnt=%0d/%0d v=%b, required 0/0 0", stall_cnt, s_stall_cnt, out_valid);
        end
    endtask

    task automatic test_rst_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_4000, 32'h2404_0004);
        cyc();
        drive(1'b1, 32'h0000_4004, 32'h2405_0005);
        cyc();
        checks++;
        if (in_ready !== 1'b0 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rf_setup: got rdy=%b cnt=%0d, required 0 1", in_ready, stall_cnt);
        end
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h0000_3010, 32'h2403_0003);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_ins !== NOP || out_pc4 !== RPC || in_ready !== 1'b1 ||
            stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_flush: got v=%b ins=%h pc4=%h rdy=%b cnt=%0d/%0d, required 0 %h %h 1 0/0",
                     out_valid, out_ins, out_pc4, in_ready, stall_cnt, s_stall_cnt, NOP, RPC);
        end
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || out_pc4 !== RPC) begin
            errors++;
            $display("FAIL rf_after: got v=%b pc4=%h, required 0 %h", out_valid, out_pc4, RPC);
        end
    endtask

    initial begin
        pc_tab[0]  = 32'h0000_3004; pc_tab[1]  = 32'h0000_3008; pc_tab[2]  = 32'h0000_300C;
        ins_tab[0] = 32'h2401_0001; ins_tab[1] = 32'h2402_0002; ins_tab[2] = 32'h0022_1820;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_rst_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
